filter_rate_ctrl: RTL and testbench

- Sequencing controller for the I/Q root-raised-cosine filter bank. It owns the baud-rate setting the bank runs at and generates single-clock sample/symbol strobes from the 76800 Hz system clock, replacing divided clocks.
- It runs safe rate switchovers: mute output at a symbol boundary, flush filter state, refill at the new rate, then unmute.
- It sits between the control/register side, the upstream symbol mapper and the filter bank.

---
 rtl/filter_rate_ctrl.sv | 88 ++++++++
 tb/tb_filter_rate_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/filter_rate_ctrl.sv
// Rate controller for the I/Q RRC filter bank: one-cycle sample/symbol strobes
// from a free-running divider, and mute/flush/settle sequencing on baud changes.
module filter_rate_ctrl #(
  parameter logic [1:0] RESET_RATE     = 2'b11,
  parameter int         FLUSH_CYCLES   = 16,
  parameter int         SETTLE_SYMBOLS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_rate,
  output logic       cfg_ready,
  output logic       cfg_done,
  output logic [1:0] active_rate,
  output logic [3:0] filt_sel,
  output logic       filt_flush,
  output logic       sample_stb,
  output logic       symbol_stb,
  output logic       mute,
  output logic       busy
);

  typedef enum logic [1:0] {RUN, MUTE, FLUSH, SETTLE} state_t;

  localparam logic [7:0] FLUSH_LAST  = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_SYMBOLS - 1);

  state_t     state, state_nxt;
  logic [4:0] div;
  logic [7:0] cnt;
  logic [1:0] pend_rate;
  logic [2:0] smask;
  logic       acc_new, acc_same, done_nxt;

  // Slower rates leave more low div bits unmasked: 0,1,3,7 for codes 11..00.
  assign smask      = 3'b111 >> active_rate;
  assign sample_stb = ((div & {2'b00, smask}) == 5'd0) && (state != FLUSH);
  assign symbol_stb = ((div & {smask, 2'b11}) == 5'd0) && (state != FLUSH);

  assign cfg_ready  = (state == RUN);
  assign busy       = (state != RUN);
  assign mute       = (state != RUN);
  assign filt_flush = (state == FLUSH);
  assign filt_sel   = 4'b0001 << active_rate;

  assign acc_new  = (state == RUN) && cfg_valid && (cfg_rate != active_rate);
  assign acc_same = (state == RUN) && cfg_valid && (cfg_rate == active_rate);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      RUN: begin
        if (acc_new)  state_nxt = MUTE;
        if (acc_same) done_nxt  = 1'b1;
      end
      MUTE:   if (symbol_stb) state_nxt = FLUSH;
      FLUSH:  if (cnt == FLUSH_LAST) state_nxt = SETTLE;
      SETTLE: if (symbol_stb && cnt == SETTLE_LAST) begin
        state_nxt = RUN;
        done_nxt  = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      div         <= 5'd0;
      cnt         <= 8'd0;
      pend_rate   <= RESET_RATE;
      active_rate <= RESET_RATE;
      cfg_done    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cfg_done <= done_nxt;
      // Divider parks at 0 through FLUSH so SETTLE starts on a symbol boundary.
      if (state_nxt == FLUSH || state == FLUSH) div <= 5'd0;
      else                                      div <= div + 5'd1;
      if (state_nxt != state)                             cnt <= 8'd0;
      else if (state == FLUSH || (state == SETTLE && symbol_stb)) cnt <= cnt + 8'd1;
      if (acc_new) pend_rate <= cfg_rate;
      if (state == MUTE && state_nxt == FLUSH) active_rate <= pend_rate;
    end
  end

endmodule

// File: tb/tb_filter_rate_ctrl.sv
// Directed bench for filter_rate_ctrl: strobes, rate switch timing, same-rate
// requests, held requests and reset during flush.
module tb_filter_rate_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic [1:0] cfg_rate;
  logic       cfg_ready, cfg_done, filt_flush, sample_stb, symbol_stb, mute, busy;
  logic [1:0] active_rate;
  logic [3:0] filt_sel;

  int checks = 0;
  int failures = 0;

  filter_rate_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_rate(cfg_rate),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .active_rate(active_rate),
    .filt_sel(filt_sel), .filt_flush(filt_flush), .sample_stb(sample_stb),
    .symbol_stb(symbol_stb), .mute(mute), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rdy"},   cfg_ready,   1);
    chk({tag, "_done"},  cfg_done,    0);
    chk({tag, "_flush"}, filt_flush,  0);
    chk({tag, "_mute"},  mute,        0);
    chk({tag, "_busy"},  busy,        0);
    chk({tag, "_rate"},  active_rate, 2'b11);
    chk({tag, "_sel"},   filt_sel,    4'b1000);
    chk({tag, "_sstb"},  sample_stb,  1);
    chk({tag, "_ystb"},  symbol_stb,  1);
  endtask

  // Full request handshake, waiting for the switch to finish.
  task automatic set_rate(input logic [1:0] r, input string tag);
    int k = 0;
    chk({tag, "_rdy"}, cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_rate  = r;
    step();
    cfg_valid = 1'b0;
    while (busy && k < 2000) begin step(); k++; end
    chk({tag, "_timeout"}, (k < 2000), 1);
    chk({tag, "_done"}, cfg_done, 1);
    chk({tag, "_rate"}, active_rate, r);
  endtask

  // Align on symbol_stb, then distance to next sample_stb and next symbol_stb.
  task automatic meas(input int sp_exp, input int yp_exp, input string tag);
    int k = 0, sp = 0, yp = 0;
    while (!symbol_stb && k < 64) begin step(); k++; end
    for (int i = 1; i <= 64 && yp == 0; i++) begin
      step();
      if (sample_stb && sp == 0) sp = i;
      if (symbol_stb) yp = i;
    end
    chk({tag, "_sper"}, sp, sp_exp);
    chk({tag, "_yper"}, yp, yp_exp);
  endtask

  initial begin
    int n, dn, fl;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_rate = 2'b00;
    #12;
    chk_reset_outs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Cycle 0 is this period; rate 11 -> sample every cycle, symbol every 4th.
    for (int c = 0; c < 64; c++) begin
      chk("r11_sstb", sample_stb, 1);
      chk("r11_ystb", symbol_stb, (c % 4 == 0));
      chk("r11_misc", {cfg_ready, mute, filt_sel}, {1'b1, 1'b0, 4'b1000});
      step();
    end

    // Cycle 64 (div=0, boundary on accept cycle does not count): 11 -> 00.
    cfg_valid = 1'b1; cfg_rate = 2'b00;
    step();
    cfg_valid = 1'b0;
    chk("sw_mute_t1", {mute, busy, cfg_ready, filt_flush}, 4'b1100);
    n = 0;
    while (!filt_flush && n < 50) begin step(); n++; end
    chk("sw_flush_start", n, 4);
    chk("sw_flush_rate", active_rate, 2'b00);
    chk("sw_flush_sel", filt_sel, 4'b0001);
    chk("sw_flush_stb", {sample_stb, symbol_stb}, 2'b00);
    n = 0;
    while (filt_flush && n < 100) begin step(); n++; end
    chk("sw_flush_len", n, 16);
    chk("sw_settle_stb", {sample_stb, symbol_stb, mute}, 3'b111);
    n = 0; dn = 0;
    while (busy && n < 1000) begin dn += cfg_done; step(); n++; end
    chk("sw_settle_len", n, 225);
    chk("sw_settle_nodone", dn, 0);
    chk("sw_run", {cfg_done, mute, cfg_ready}, 3'b101);
    step();
    chk("sw_done_pulse", cfg_done, 0);
    meas(8, 32, "r00");

    // Held request to 01: exactly one acceptance and one cfg_done.
    cfg_valid = 1'b1; cfg_rate = 2'b01;
    step();
    n = 0; dn = 0;
    while (busy && n < 2000) begin dn += cfg_done; step(); n++; end
    cfg_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin dn += cfg_done; step(); end
    chk("hold_done_cnt", dn, 1);
    chk("hold_rate", active_rate, 2'b01);
    meas(4, 16, "r01");

    set_rate(2'b10, "to10");
    meas(2, 8, "r10");
    set_rate(2'b11, "to11");
    meas(1, 4, "r11");

    // Same-rate request: done one cycle later, no flush, no mute.
    cfg_valid = 1'b1; cfg_rate = 2'b11;
    step();
    cfg_valid = 1'b0;
    chk("same_done", {cfg_done, mute, busy}, 3'b100);
    dn = 0; fl = 0;
    for (int i = 0; i < 20; i++) begin step(); dn += cfg_done; fl += filt_flush | mute; end
    chk("same_quiet", {dn[7:0], fl[7:0]}, 16'h0000);

    // Reset during FLUSH aborts the switch.
    cfg_valid = 1'b1; cfg_rate = 2'b00;
    step();
    cfg_valid = 1'b0;
    n = 0;
    while (!filt_flush && n < 50) begin step(); n++; end
    chk("rf_in_flush", filt_flush, 1);
    step(); step();
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rf_async");
    #4;
    @(posedge clk); #2;
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      dn += cfg_done;
      if (!sample_stb) dn += 100;
      step();
    end
    chk("rf_after", {active_rate, dn[7:0]}, {2'b11, 8'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
